mem_access: RTL and testbench

- MEM pipeline stage plus MEM/WB pipeline register; sits directly upstream of the write-back stage.
- Accepts EX/MEM results, performs data-memory loads/stores over a req/ack handshake, and aligns load data.
- Registers ALUData, MemData, MemtoReg, RegWrite and DestReg for the write-back stage, which selects between ALUData and MemData.
- Stalls the upstream pipeline while a memory transaction is outstanding; flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_if.sv | 29 ++
 rtl/mem_access.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_access.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_if
//  Description : Data-memory request/acknowledge bus between the MEM stage
//                (master) and the data memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  // MEM stage side: issues requests, consumes completion and read data
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  // Memory side: observes requests, returns completion and read data
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : MEM pipeline stage plus MEM/WB pipeline register. Issues
//                data-memory loads/stores over a req/ack bus, aligns and
//                extends load data, stalls upstream while a transaction is
//                outstanding, and flags misaligned accesses and bus timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        in_valid,
  input  wire logic        MemRead,
  input  wire logic        MemWrite,
  input  wire logic        MemtoRegIn,
  input  wire logic        RegWriteIn,
  input  wire logic [4:0]  DestRegIn,
  input  wire logic [1:0]  AccSize,
  input  wire logic        SignExt,
  input  wire logic [31:0] ALUResult,
  input  wire logic [31:0] StoreData,
  output logic             stall_out,
  mem_access_if.master     bus,
  output logic             wb_valid,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [4:0]       DestReg,
  output logic [31:0]      ALUData,
  output logic [31:0]      MemData,
  output logic             AddrExc,
  output logic             BusErr
);

  // The wait counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_REQ  = 1'b1;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  logic [0:0]         r_state;
  logic [0:0]         w_next_state;
  logic [c_CNT_W-1:0] r_cnt;

  // Request held for the life of the transaction
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_sext;
  logic        r_memtoreg;
  logic        r_regwrite;
  logic [4:0]  r_dest;
  logic [31:0] r_alu;

  logic        w_is_mem;
  logic        w_illegal;
  logic        w_exc;
  logic        w_accept;
  logic        w_start;
  logic        w_ack_done;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Classify the incoming EX/MEM operation.
  always_comb begin
    w_is_mem  = MemRead | MemWrite;
    w_illegal = (MemRead & MemWrite)
              | (AccSize == 2'b11)
              | ((AccSize == c_SZ_HALF) & ALUResult[0])
              | ((AccSize == c_SZ_WORD) & (ALUResult[1:0] != 2'b00));
    // AccSize is meaningless for non-memory ops, so only mem ops can fault
    w_exc      = w_is_mem & w_illegal;
    w_accept   = (r_state == c_IDLE) & in_valid;
    w_start    = w_accept & w_is_mem & ~w_exc;
    w_ack_done = (r_state == c_REQ) & bus.dmem_ack;
    // An ack in the final wait cycle takes priority over the abort
    w_timeout  = (r_state == c_REQ) & ~bus.dmem_ack & (r_cnt == c_CNT_LAST);
  end

  // Byte enables and lane-replicated write data for the request being captured.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (MemWrite) begin
      case (AccSize)
        c_SZ_BYTE: begin
          w_be    = 4'b0001 << ALUResult[1:0];
          w_wdata = {4{StoreData[7:0]}};
        end
        c_SZ_HALF: begin
          w_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{StoreData[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = StoreData;
        end
      endcase
    end
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = bus.dmem_rdata[7:0];
      2'd1:    w_byte = bus.dmem_rdata[15:8];
      2'd2:    w_byte = bus.dmem_rdata[23:16];
      default: w_byte = bus.dmem_rdata[31:24];
    endcase
    w_half = r_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (r_size)
      c_SZ_BYTE: w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      c_SZ_HALF: w_load = {{16{r_sext & w_half[15]}}, w_half};
      default:   w_load = bus.dmem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic: leave IDLE on a legal mem op, leave REQ on ack or timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_start) w_next_state = c_REQ;
      c_REQ:   if (w_ack_done || w_timeout) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // FSM outputs: the request is live and upstream is held exactly while in REQ.
  always_comb begin
    stall_out    = (r_state == c_REQ);
    bus.dmem_req = (r_state == c_REQ);
  end

  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_be    = r_be;
  assign bus.dmem_wdata = r_wdata;

  // Capture a legal request on entry to REQ and count wait cycles while in REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_addr     <= 32'h0;
      r_we       <= 1'b0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_sext     <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_dest     <= 5'd0;
      r_alu      <= 32'h0;
    end else if (w_start) begin
      r_cnt      <= '0;
      r_addr     <= {ALUResult[31:2], 2'b00};
      r_we       <= MemWrite;
      r_be       <= w_be;
      r_wdata    <= w_wdata;
      r_off      <= ALUResult[1:0];
      r_size     <= AccSize;
      r_sext     <= SignExt;
      r_memtoreg <= MemtoRegIn;
      r_regwrite <= RegWriteIn;
      r_dest     <= DestRegIn;
      r_alu      <= ALUResult;
    end else if ((r_state == c_REQ) && !bus.dmem_ack && (r_cnt != c_CNT_LAST)) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // MEM/WB register: updated on a direct result, a completed access or an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      MemtoReg <= 1'b0;
      RegWrite <= 1'b0;
      DestReg  <= 5'd0;
      ALUData  <= 32'h0;
      MemData  <= 32'h0;
      AddrExc  <= 1'b0;
      BusErr   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (w_accept && !w_start) begin
        wb_valid <= 1'b1;
        MemtoReg <= MemtoRegIn;
        RegWrite <= RegWriteIn & ~w_exc;
        DestReg  <= DestRegIn;
        ALUData  <= ALUResult;
        MemData  <= 32'h0;
        AddrExc  <= w_exc;
        BusErr   <= 1'b0;
      end else if (w_ack_done) begin
        wb_valid <= 1'b1;
        MemtoReg <= r_memtoreg;
        RegWrite <= r_regwrite;
        DestReg  <= r_dest;
        ALUData  <= r_alu;
        MemData  <= r_we ? 32'h0 : w_load;
        AddrExc  <= 1'b0;
        BusErr   <= 1'b0;
      end else if (w_timeout) begin
        wb_valid <= 1'b1;
        MemtoReg <= r_memtoreg;
        RegWrite <= 1'b0;
        DestReg  <= r_dest;
        ALUData  <= r_alu;
        MemData  <= 32'h0;
        AddrExc  <= 1'b0;
        BusErr   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access: directed scenarios plus
//                randomized operations against a behavioural model of the
//                MEM stage and MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        in_valid, MemRead, MemWrite, MemtoRegIn, RegWriteIn, SignExt;
  logic [4:0]  DestRegIn;
  logic [1:0]  AccSize;
  logic [31:0] ALUResult, StoreData;
  logic        stall_out, wb_valid, MemtoReg, RegWrite, AddrExc, BusErr;
  logic [4:0]  DestReg;
  logic [31:0] ALUData, MemData;

  mem_access_if bus ();

  mem_access #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn),
    .DestRegIn(DestRegIn), .AccSize(AccSize), .SignExt(SignExt),
    .ALUResult(ALUResult), .StoreData(StoreData), .stall_out(stall_out),
    .bus(bus), .wb_valid(wb_valid), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .DestReg(DestReg), .ALUData(ALUData), .MemData(MemData),
    .AddrExc(AddrExc), .BusErr(BusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected MEM/WB contents
  logic [31:0] e_alu, e_mem;
  logic        e_m2r, e_rw, e_aexc, e_berr;
  logic [4:0]  e_dest;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Load result from the spec's rules: shift the addressed bytes down, mask, extend.
  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sx);
    int nb, off;
    logic [31:0] v, m;
    nb  = 1 << sz;
    off = int'(a % 4);
    v   = rd >> (8 * off);
    m   = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v   = v & m;
    if (sx && nb < 4 && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  task automatic clear_model();
    e_alu = 0; e_mem = 0; e_m2r = 0; e_rw = 0; e_aexc = 0; e_berr = 0; e_dest = 0;
  endtask

  task automatic check_wb(input string tag);
    chk({tag, "_wbv"},  wb_valid, 1);
    chk({tag, "_alu"},  ALUData,  e_alu);
    chk({tag, "_mem"},  MemData,  e_mem);
    chk({tag, "_m2r"},  MemtoReg, e_m2r);
    chk({tag, "_rw"},   RegWrite, e_rw);
    chk({tag, "_dest"}, DestReg,  e_dest);
    chk({tag, "_aexc"}, AddrExc,  e_aexc);
    chk({tag, "_berr"}, BusErr,   e_berr);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wbv"},   wb_valid, 0);
    chk({tag, "_stall"}, stall_out, 0);
    chk({tag, "_req"},   bus.dmem_req, 0);
    chk({tag, "_we"},    bus.dmem_we, 0);
    chk({tag, "_addr"},  bus.dmem_addr, 0);
    chk({tag, "_be"},    bus.dmem_be, 0);
    chk({tag, "_wdata"}, bus.dmem_wdata, 0);
    chk({tag, "_outs"},  {MemtoReg, RegWrite, DestReg, AddrExc, BusErr}, 0);
    chk({tag, "_alu"},   ALUData, 0);
    chk({tag, "_mem"},   MemData, 0);
  endtask

  task automatic drive(input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [4:0] dest, input logic [1:0] size, input logic sx,
                       input logic [31:0] alu, input logic [31:0] sd);
    in_valid = 1; MemRead = mr; MemWrite = mw; MemtoRegIn = m2r; RegWriteIn = rw;
    DestRegIn = dest; AccSize = size; SignExt = sx; ALUResult = alu; StoreData = sd;
  endtask

  // One complete operation, started at a negedge; ack_wait = wait cycles before ack, <0 = never.
  task automatic run_op(input string tag, input logic mr, input logic mw, input logic m2r,
                        input logic rw, input logic [4:0] dest, input logic [1:0] size,
                        input logic sx, input logic [31:0] alu, input logic [31:0] sd,
                        input int ack_wait, input logic [31:0] rdata);
    int nb, off, n_req, held;
    logic is_mem, illegal, tmo;
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr;
    nb      = 1 << size;
    off     = int'(alu % 4);
    is_mem  = mr | mw;
    illegal = is_mem && ((mr && mw) || size == 2'b11 || (alu % nb) != 0);
    drive(mr, mw, m2r, rw, dest, size, sx, alu, sd);
    bus.dmem_ack = 0;
    @(negedge clk);
    in_valid = 0;
    if (!is_mem || illegal) begin
      e_alu = alu; e_mem = 0; e_m2r = m2r; e_rw = rw && !illegal; e_dest = dest;
      e_aexc = illegal; e_berr = 0;
      chk({tag, "_noreq"},   bus.dmem_req, 0);
      chk({tag, "_nostall"}, stall_out, 0);
      check_wb(tag);
    end else begin
      eaddr = alu & ~32'h3;
      for (int i = 0; i < 4; i++) begin
        ebe[i] = mr ? 1'b1 : (i >= off && i < off + nb);
        ewd[8*i +: 8] = sd[8*(i % nb) +: 8];
      end
      chk({tag, "_req"},  bus.dmem_req, 1);
      chk({tag, "_we"},   bus.dmem_we, mw);
      chk({tag, "_addr"}, bus.dmem_addr, eaddr);
      chk({tag, "_be"},   bus.dmem_be, ebe);
      if (mw) chk({tag, "_wdata"}, bus.dmem_wdata, ewd);
      tmo   = !(ack_wait >= 0 && ack_wait < TIMEOUT);
      n_req = tmo ? TIMEOUT : ack_wait + 1;
      held  = 0;
      for (int k = 0; k < n_req; k++) begin
        if (bus.dmem_req === 1'b1 && stall_out === 1'b1 && bus.dmem_addr === eaddr &&
            bus.dmem_be === ebe && bus.dmem_we === mw && wb_valid === 1'b0) held++;
        bus.dmem_ack   = (k == ack_wait);
        bus.dmem_rdata = (k == ack_wait) ? rdata : $urandom;
        ALUResult = $urandom; StoreData = $urandom;
        @(negedge clk);
      end
      bus.dmem_ack = 0;
      chk({tag, "_held"},    held, n_req);
      chk({tag, "_reqdrop"}, bus.dmem_req, 0);
      chk({tag, "_unstall"}, stall_out, 0);
      e_alu = alu; e_m2r = m2r; e_dest = dest; e_aexc = 0;
      if (tmo) begin
        e_mem = 0; e_rw = 0; e_berr = 1;
      end else begin
        e_mem = mr ? exp_load(rdata, alu, size, sx) : 32'h0; e_rw = rw; e_berr = 0;
      end
      check_wb(tag);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, wb_valid, 0);
    chk({tag, "_hold"},  ALUData, e_alu);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; in_valid = 0; MemRead = 0; MemWrite = 0; MemtoRegIn = 0; RegWriteIn = 0;
    DestRegIn = 0; AccSize = 0; SignExt = 0; ALUResult = 0; StoreData = 0;
    bus.dmem_ack = 0; bus.dmem_rdata = 0;
    clear_model();
    @(negedge clk); @(negedge clk);
    check_zero("rst");
    rst = 0;
    @(negedge clk);
    check_zero("postrst");

    // ALU pass-through
    run_op("alu", 0, 0, 0, 1, 5'd7, 2'b00, 0, 32'h1234_5678, 0, 0, 0);
    chk("alu_const", ALUData, 32'h1234_5678);

    // LB signed from lane 3, ack in the request cycle
    run_op("lb", 1, 0, 1, 1, 5'd3, 2'b00, 1, 32'h0000_0103, 0, 0, 32'h80AA_BBCC);
    chk("lb_const", MemData, 32'hFFFF_FF80);

    // SH upper half with three wait cycles (ack in the final allowed cycle)
    run_op("sh", 0, 1, 0, 0, 5'd0, 2'b01, 0, 32'h0000_0202, 32'h0000_BEEF, 3, 0);

    // Misaligned LW
    run_op("lwmis", 1, 0, 1, 1, 5'd9, 2'b10, 0, 32'h0000_0006, 0, 0, 0);
    chk("lwmis_const", AddrExc, 1);

    // LW with no ack: timeout, then a late ack must be ignored
    run_op("lwto", 1, 0, 1, 1, 5'd11, 2'b10, 0, 32'h0000_0040, 0, -1, 0);
    bus.dmem_ack = 1; bus.dmem_rdata = $urandom;
    @(negedge clk);
    bus.dmem_ack = 0;
    chk("late_wbv", wb_valid, 0);
    chk("late_req", bus.dmem_req, 0);
    chk("late_berr", BusErr, 1);
    chk("late_mem", MemData, 0);

    // Reset one cycle into REQ of an LHU
    drive(1, 0, 1, 1, 5'd4, 2'b01, 0, 32'h0000_0002, 0);
    @(negedge clk);
    in_valid = 0;
    chk("rstreq_req", bus.dmem_req, 1);
    rst = 1; bus.dmem_ack = 1; bus.dmem_rdata = 32'h9ABC_0000;
    @(negedge clk);
    bus.dmem_ack = 0;
    check_zero("rstreq");
    rst = 0;
    clear_model();
    @(negedge clk);
    chk("rstreq_nowb", wb_valid, 0);
    run_op("alu2", 0, 0, 1, 1, 5'd21, 2'b11, 1, 32'hCAFE_0001, 0, 0, 0);

    // Back-to-back ALU ops, one per cycle
    drive(0, 0, 0, 1, 5'd1, 2'b00, 0, 32'hAAAA_0001, 0);
    @(negedge clk);
    chk("b2b1_wbv", wb_valid, 1);
    chk("b2b1_alu", ALUData, 32'hAAAA_0001);
    drive(0, 0, 0, 1, 5'd2, 2'b00, 0, 32'hBBBB_0002, 0);
    @(negedge clk);
    in_valid = 0;
    chk("b2b2_wbv", wb_valid, 1);
    chk("b2b2_alu", ALUData, 32'hBBBB_0002);
    chk("b2b2_dest", DestReg, 2);
    @(negedge clk);
    chk("b2b_end", wb_valid, 0);
    e_alu = 32'hBBBB_0002; e_mem = 0; e_m2r = 0; e_rw = 1; e_dest = 2; e_aexc = 0; e_berr = 0;

    // Randomized operations
    for (int n = 0; n < 250; n++) begin
      int kind, aw;
      logic mr, mw;
      logic [1:0] sz;
      kind = $urandom_range(0, 9);
      mr = (kind >= 3 && kind <= 5) || kind == 9;
      mw = (kind >= 6);
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      aw = $urandom_range(0, 5);
      if (aw == 5) aw = -1;
      run_op("rnd", mr, mw, 1'($urandom), 1'($urandom), 5'($urandom), sz, 1'($urandom),
             $urandom, $urandom, aw, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
